// File: rtl/gpu_pkg.sv
// Shared encodings for the GPU core: core FSM states, write-back source
// selects and special-register offsets from the top of each lane's file.
package gpu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        FETCH   = 3'b001,
        DECODE  = 3'b010,
        REQUEST = 3'b011,
        WAIT    = 3'b100,
        EXECUTE = 3'b101,
        UPDATE  = 3'b110,
        DONE    = 3'b111
    } core_state_e;

    typedef enum logic [1:0] {
        ARITH  = 2'b00,
        MEMORY = 2'b01,
        CONST  = 2'b10,
        MOVE   = 2'b11
    } reg_input_mux_e;

    // Special registers sit at NUM_REGS minus these offsets
    localparam int BLOCK_ID_OFS   = 3;
    localparam int BLOCK_DIM_OFS  = 2;
    localparam int THREAD_IDX_OFS = 1;

    function automatic int special_base(input int num_regs);
        return num_regs - BLOCK_ID_OFS;
    endfunction

endpackage

// File: rtl/register_lane.sv
// One lane of the warp register file: NUM_REGS x DATA_BITS storage plus
// registered rs/rt read ports.
module register_lane #(
    parameter  int DATA_BITS = 8,
    parameter  int NUM_REGS  = 16,
    parameter  int LANE_ID   = 0,
    localparam int ADDR_BITS = $clog2(NUM_REGS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 active,
    input  logic [2:0]           core_state,
    input  logic                 reg_write_enable,
    input  logic [1:0]           reg_input_mux,
    input  logic [ADDR_BITS-1:0] rs_address,
    input  logic [ADDR_BITS-1:0] rt_address,
    input  logic [ADDR_BITS-1:0] rd_address,
    input  logic [DATA_BITS-1:0] alu_in,
    input  logic [DATA_BITS-1:0] lsu_in,
    input  logic [DATA_BITS-1:0] immediate,
    input  logic [DATA_BITS-1:0] block_id,
    input  logic [DATA_BITS-1:0] block_dim,
    output logic [DATA_BITS-1:0] rs_data,
    output logic [DATA_BITS-1:0] rt_data
);
    import gpu_pkg::*;

    localparam int BLOCK_ID_IDX   = NUM_REGS - BLOCK_ID_OFS;
    localparam int BLOCK_DIM_IDX  = NUM_REGS - BLOCK_DIM_OFS;
    localparam int THREAD_IDX_IDX = NUM_REGS - THREAD_IDX_OFS;
    localparam logic [ADDR_BITS-1:0] SPECIAL_BASE =
        ADDR_BITS'(special_base(NUM_REGS));

    logic [DATA_BITS-1:0] regs_q [NUM_REGS];
    logic [DATA_BITS-1:0] regs_d [NUM_REGS];
    logic [DATA_BITS-1:0] rs_q, rs_d;
    logic [DATA_BITS-1:0] rt_q, rt_d;
    logic [DATA_BITS-1:0] wr_data;
    logic                 do_read;
    logic                 do_write;

    always_comb begin
        wr_data = alu_in;
        unique case (reg_input_mux)
            ARITH:  wr_data = alu_in;
            MEMORY: wr_data = lsu_in;
            CONST:  wr_data = immediate;
            MOVE:   wr_data = rs_q;
        endcase
    end

    assign do_read  = enable && active && (core_state == REQUEST);
    assign do_write = enable && active && (core_state == UPDATE)
                   && reg_write_enable && (rd_address < SPECIAL_BASE);

    always_comb begin
        regs_d = regs_q;
        rs_d   = rs_q;
        rt_d   = rt_q;
        // Reads see pre-edge contents, including the special registers
        if (do_read) begin
            rs_d = regs_q[rs_address];
            rt_d = regs_q[rt_address];
        end
        if (do_write) begin
            regs_d[rd_address] = wr_data;
        end
        if (enable) begin
            regs_d[BLOCK_ID_IDX]  = block_id;
            regs_d[BLOCK_DIM_IDX] = block_dim;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == THREAD_IDX_IDX)
                           ? DATA_BITS'(LANE_ID) : '0;
            end
            rs_q <= '0;
            rt_q <= '0;
        end else begin
            regs_q <= regs_d;
            rs_q   <= rs_d;
            rt_q   <= rt_d;
        end
    end

    assign rs_data = rs_q;
    assign rt_data = rt_q;

endmodule

// File: rtl/warp_register_file.sv
// Warp-wide register file: THREADS independent lanes sharing decode
// controls, with per-lane data buses packed lane i at [i*DATA_BITS +: DATA_BITS].
module warp_register_file #(
    parameter  int DATA_BITS = 8,
    parameter  int NUM_REGS  = 16,
    parameter  int THREADS   = 4,
    localparam int ADDR_BITS = $clog2(NUM_REGS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [2:0]                   core_state,
    input  logic [THREADS-1:0]           thread_mask,
    input  logic                         reg_write_enable,
    input  logic [1:0]                   reg_input_mux,
    input  logic [ADDR_BITS-1:0]         rs_address,
    input  logic [ADDR_BITS-1:0]         rt_address,
    input  logic [ADDR_BITS-1:0]         rd_address,
    input  logic [THREADS*DATA_BITS-1:0] alu_out,
    input  logic [THREADS*DATA_BITS-1:0] lsu_out,
    input  logic [DATA_BITS-1:0]         immediate,
    input  logic [DATA_BITS-1:0]         block_id,
    input  logic [DATA_BITS-1:0]         block_dim,
    output logic [THREADS*DATA_BITS-1:0] rs_data,
    output logic [THREADS*DATA_BITS-1:0] rt_data
);

    for (genvar g = 0; g < THREADS; g++) begin : g_lane
        register_lane #(
            .DATA_BITS (DATA_BITS),
            .NUM_REGS  (NUM_REGS),
            .LANE_ID   (g)
        ) u_lane (
            .clock            (clock),
            .reset            (reset),
            .enable           (enable),
            .active           (thread_mask[g]),
            .core_state       (core_state),
            .reg_write_enable (reg_write_enable),
            .reg_input_mux    (reg_input_mux),
            .rs_address       (rs_address),
            .rt_address       (rt_address),
            .rd_address       (rd_address),
            .alu_in           (alu_out[g*DATA_BITS +: DATA_BITS]),
            .lsu_in           (lsu_out[g*DATA_BITS +: DATA_BITS]),
            .immediate        (immediate),
            .block_id         (block_id),
            .block_dim        (block_dim),
            .rs_data          (rs_data[g*DATA_BITS +: DATA_BITS]),
            .rt_data          (rt_data[g*DATA_BITS +: DATA_BITS])
        );
    end

endmodule

// File: tb/tb_warp_register_file.sv
// Directed bench for warp_register_file: array model checked every cycle
// plus literal expectations from hand-worked vectors.
module tb_warp_register_file;

    localparam int DW = 8;
    localparam int NR = 16;
    localparam int TH = 4;
    localparam int AW = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic [2:0]        core_state;
    logic [TH-1:0]     thread_mask;
    logic              reg_write_enable;
    logic [1:0]        reg_input_mux;
    logic [AW-1:0]     rs_address;
    logic [AW-1:0]     rt_address;
    logic [AW-1:0]     rd_address;
    logic [TH*DW-1:0]  alu_out;
    logic [TH*DW-1:0]  lsu_out;
    logic [DW-1:0]     immediate;
    logic [DW-1:0]     block_id;
    logic [DW-1:0]     block_dim;
    logic [TH*DW-1:0]  rs_data;
    logic [TH*DW-1:0]  rt_data;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: plain arrays of register contents per lane
    logic [DW-1:0] m_reg [TH][NR];
    logic [DW-1:0] m_rs  [TH];
    logic [DW-1:0] m_rt  [TH];
    bit            m_valid = 0;

    warp_register_file #(
        .DATA_BITS (DW),
        .NUM_REGS  (NR),
        .THREADS   (TH)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .core_state       (core_state),
        .thread_mask      (thread_mask),
        .reg_write_enable (reg_write_enable),
        .reg_input_mux    (reg_input_mux),
        .rs_address       (rs_address),
        .rt_address       (rt_address),
        .rd_address       (rd_address),
        .alu_out          (alu_out),
        .lsu_out          (lsu_out),
        .immediate        (immediate),
        .block_id         (block_id),
        .block_dim        (block_dim),
        .rs_data          (rs_data),
        .rt_data          (rt_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        logic [DW-1:0] src;
        if (reset) begin
            for (int l = 0; l < TH; l++) begin
                for (int r = 0; r < NR; r++) m_reg[l][r] = 8'h00;
                m_reg[l][NR-1] = DW'(l);
                m_rs[l] = 8'h00;
                m_rt[l] = 8'h00;
            end
            m_valid = 1;
        end else if (enable) begin
            for (int l = 0; l < TH; l++) begin
                if (core_state == 3'b011 && thread_mask[l]) begin
                    m_rs[l] = m_reg[l][rs_address];
                    m_rt[l] = m_reg[l][rt_address];
                end
                if (core_state == 3'b110 && thread_mask[l]
                    && reg_write_enable && int'(rd_address) < NR - 3) begin
                    case (reg_input_mux)
                        2'b00:   src = alu_out[l*DW +: DW];
                        2'b01:   src = lsu_out[l*DW +: DW];
                        2'b10:   src = immediate;
                        default: src = m_rs[l];
                    endcase
                    m_reg[l][rd_address] = src;
                end
                m_reg[l][NR-3] = block_id;
                m_reg[l][NR-2] = block_dim;
            end
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            for (int l = 0; l < TH; l++) begin
                vectors++;
                if (rs_data[l*DW +: DW] !== m_rs[l]) begin
                    miscompares++;
                    $display("FAIL model rs lane%0d t=%0t got %h want %h",
                             l, $time, rs_data[l*DW +: DW], m_rs[l]);
                end
                vectors++;
                if (rt_data[l*DW +: DW] !== m_rt[l]) begin
                    miscompares++;
                    $display("FAIL model rt lane%0d t=%0t got %h want %h",
                             l, $time, rt_data[l*DW +: DW], m_rt[l]);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk(input string nm, input logic [TH*DW-1:0] got,
                       input logic [TH*DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    task automatic idle();
        core_state       = 3'b000;
        reg_write_enable = 1'b0;
        thread_mask      = 4'b1111;
    endtask

    task automatic req(input logic [AW-1:0] rs, input logic [AW-1:0] rt);
        idle();
        core_state = 3'b011;
        rs_address = rs;
        rt_address = rt;
        tick();
    endtask

    task automatic upd(input logic [AW-1:0] rd, input logic [1:0] mux);
        idle();
        core_state       = 3'b110;
        reg_write_enable = 1'b1;
        rd_address       = rd;
        reg_input_mux    = mux;
        tick();
    endtask

    initial begin
        reset            = 1'b1;
        enable           = 1'b1;
        core_state       = 3'b000;
        thread_mask      = 4'b1111;
        reg_write_enable = 1'b0;
        reg_input_mux    = 2'b00;
        rs_address       = '0;
        rt_address       = '0;
        rd_address       = '0;
        alu_out          = '0;
        lsu_out          = '0;
        immediate        = '0;
        block_id         = '0;
        block_dim        = '0;
        tick();
        reset = 1'b0;
        chk("reset_rs", rs_data, 32'h0);
        chk("reset_rt", rt_data, 32'h0);

        req(4'd15, 4'd0);
        chk("thread_idx", rs_data, 32'h03020100);
        chk("reg0_zero", rt_data, 32'h0);

        block_id  = 8'hAA;
        block_dim = 8'h04;
        idle();
        tick();
        req(4'd13, 4'd14);
        chk("block_id", rs_data, 32'hAAAAAAAA);
        chk("block_dim", rt_data, 32'h04040404);

        alu_out = 32'h44332211;
        upd(4'd5, 2'b00);
        req(4'd5, 4'd0);
        chk("alu_write", rs_data, 32'h44332211);

        immediate = 8'hA5;
        upd(4'd6, 2'b10);
        thread_mask = 4'b0101;
        tick();
        req(4'd6, 4'd0);
        lsu_out = 32'hF0F0F0F0;
        upd(4'd7, 2'b01);
        req(4'd7, 4'd6);
        chk("lsu_write", rs_data, 32'hF0F0F0F0);
        chk("imm_write", rt_data, 32'hA5A5A5A5);

        // Masked immediate write: only lanes 0 and 2 updated
        idle();
        core_state       = 3'b110;
        reg_write_enable = 1'b1;
        rd_address       = 4'd9;
        reg_input_mux    = 2'b10;
        thread_mask      = 4'b0101;
        tick();
        req(4'd9, 4'd0);
        chk("mask_write", rs_data, 32'h00A500A5);

        immediate = 8'h55;
        upd(4'd13, 2'b10);
        req(4'd13, 4'd0);
        chk("ro_special", rs_data, 32'hAAAAAAAA);

        req(4'd5, 4'd0);
        upd(4'd8, 2'b11);
        req(4'd8, 4'd0);
        chk("mov_write", rs_data, 32'h44332211);

        // Masked read: lanes 2,3 keep the previous r8 values
        idle();
        core_state  = 3'b011;
        rs_address  = 4'd15;
        thread_mask = 4'b0011;
        tick();
        chk("mask_read", rs_data, 32'h44330100);

        enable    = 1'b0;
        immediate = 8'hFF;
        block_id  = 8'h77;
        upd(4'd5, 2'b10);
        chk("disable_hold", rs_data, 32'h44330100);
        enable = 1'b1;
        req(4'd5, 4'd13);
        chk("disable_r5", rs_data, 32'h44332211);
        chk("preedge_bid", rt_data, 32'hAAAAAAAA);
        req(4'd0, 4'd13);
        chk("latched_bid", rt_data, 32'h77777777);

        reset            = 1'b1;
        core_state       = 3'b110;
        reg_write_enable = 1'b1;
        rd_address       = 4'd5;
        reg_input_mux    = 2'b10;
        tick();
        reset = 1'b0;
        chk("rst_prio_rs", rs_data, 32'h0);
        chk("rst_prio_rt", rt_data, 32'h0);
        req(4'd5, 4'd15);
        chk("rst_r5", rs_data, 32'h0);
        chk("rst_tidx", rt_data, 32'h03020100);

        idle();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
